// File: rtl/rptr_empty.sv
// Read-side pointer and empty logic for an asynchronous FIFO.
// Synchronizes the Gray write pointer into rclk and drives a registered, handshaked output word.
module rptr_empty #(
  parameter int WORDSIZE      = 8,
  parameter int ADDRSIZE      = 8,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [WORDSIZE-1:0] rdata,
  input  logic                dout_ready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic [WORDSIZE-1:0] dout,
  output logic                dout_valid
);

  localparam logic [ADDRSIZE:0] ATHRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rq1_wptr;
  logic [ADDRSIZE:0] rq2_wptr;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rgray;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_sync;
  logic [ADDRSIZE:0] rcountnext;
  logic              rinc;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // wptr crosses clock domains here and nowhere else.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= wptr;
      rq2_wptr <= rq1_wptr;
    end
  end

  always_comb begin
    rinc       = !rempty && (!dout_valid || dout_ready);
    rbinnext   = rbin + {{ADDRSIZE{1'b0}}, rinc};
    rgraynext  = (rbinnext >> 1) ^ rbinnext;
    wbin_sync  = gray2bin(rq2_wptr);
    rcountnext = wbin_sync - rbinnext;
  end

  // Flags look at the pointer after this edge's pop, so empty is never late by a cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rgray   <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rcount  <= '0;
    end else begin
      rbin    <= rbinnext;
      rgray   <= rgraynext;
      rempty  <= (rgraynext == rq2_wptr);
      raempty <= (rcountnext <= ATHRESH);
      rcount  <= rcountnext;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (rinc) begin
      dout       <= rdata;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];
  assign rptr  = rgray;

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty: directed latency/backpressure/reset scenarios
// plus a randomized wrap stream checked against a queue-based FIFO model.
module tb_rptr_empty;

  logic       rclk;
  logic       rrst_n;
  logic [4:0] wptr;
  logic [7:0] rdata;
  logic       dout_ready;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rcount;
  logic [7:0] dout;
  logic       dout_valid;

  logic [7:0] mem [0:15];
  logic [7:0] q [$];
  int         wcnt;
  int         consumed;
  int         errors;
  int         checks;

  rptr_empty #(.WORDSIZE(8), .ADDRSIZE(4), .AEMPTY_THRESH(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr      (wptr),
    .rdata     (rdata),
    .dout_ready(dout_ready),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .raempty   (raempty),
    .rcount    (rcount),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  assign rdata = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst_n     = 1'b0;
    wptr       = '0;
    dout_ready = 1'b0;
    wcnt       = 0;
    consumed   = 0;
    q.delete();
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wcnt % 16] = d;
    q.push_back(d);
    wcnt = wcnt + 1;
    wptr = gray(wcnt);
  endtask

  task automatic wait_nonempty(input int budget);
    int n;
    n = 0;
    while (rempty && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (rempty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_nonempty: rempty=%0b required 0 within %0d cycles", rempty, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    checks += 6;
    if (rempty !== 1'b1)     begin errors++; $display("[TB] FAIL reset_rempty: got %0b want 1", rempty); end
    if (raempty !== 1'b1)    begin errors++; $display("[TB] FAIL reset_raempty: got %0b want 1", raempty); end
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_valid: got %0b want 0", dout_valid); end
    if (rptr !== 5'd0)       begin errors++; $display("[TB] FAIL reset_rptr: got %0h want 0", rptr); end
    if (raddr !== 4'd0)      begin errors++; $display("[TB] FAIL reset_raddr: got %0h want 0", raddr); end
    if (rcount !== 5'd0)     begin errors++; $display("[TB] FAIL reset_rcount: got %0d want 0", rcount); end
  endtask

  task automatic test_single_word();
    do_reset();
    write_word(8'hA5);
    tick();
    checks++;
    if (rempty !== 1'b1) begin errors++; $display("[TB] FAIL single_edge1_rempty: got %0b want 1", rempty); end
    tick();
    checks++;
    if (rempty !== 1'b1) begin errors++; $display("[TB] FAIL single_edge2_rempty: got %0b want 1", rempty); end
    tick();
    checks += 2;
    if (rempty !== 1'b0)     begin errors++; $display("[TB] FAIL single_edge3_rempty: got %0b want 0", rempty); end
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_edge3_valid: got %0b want 0", dout_valid); end
    tick();
    checks += 4;
    if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_edge4_valid: got %0b want 1", dout_valid); end
    if (dout !== 8'hA5)      begin errors++; $display("[TB] FAIL single_edge4_dout: got %0h want a5", dout); end
    if (raddr !== 4'd1)      begin errors++; $display("[TB] FAIL single_edge4_raddr: got %0d want 1", raddr); end
    if (rempty !== 1'b1)     begin errors++; $display("[TB] FAIL single_edge4_rempty: got %0b want 1", rempty); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_hold_valid: got %0b want 1", dout_valid); end
      if (rempty !== 1'b1)     begin errors++; $display("[TB] FAIL single_hold_rempty: got %0b want 1", rempty); end
    end
  endtask

  task automatic test_burst();
    int left;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) write_word(8'($urandom));
    dout_ready = 1'b1;
    wait_nonempty(6);
    checks += 3;
    if (rcount !== 5'd6)     begin errors++; $display("[TB] FAIL burst_start_rcount: got %0d want 6", rcount); end
    if (raempty !== 1'b0)    begin errors++; $display("[TB] FAIL burst_start_raempty: got %0b want 0", raempty); end
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_start_valid: got %0b want 0", dout_valid); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      left = 6 - k;
      exp  = (q.size() > 0) ? q.pop_front() : 8'h00;
      checks += 4;
      if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL burst_valid[%0d]: got %0b want 1", k, dout_valid); end
      if (dout !== exp)        begin errors++; $display("[TB] FAIL burst_dout[%0d]: got %0h want %0h", k, dout, exp); end
      if (int'(rcount) != left) begin errors++; $display("[TB] FAIL burst_rcount[%0d]: got %0d want %0d", k, rcount, left); end
      if (raempty !== (left <= 4)) begin errors++; $display("[TB] FAIL burst_raempty[%0d]: got %0b want %0b", k, raempty, (left <= 4)); end
    end
    checks++;
    if (rempty !== 1'b1) begin errors++; $display("[TB] FAIL burst_end_rempty: got %0b want 1", rempty); end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_drained_valid: got %0b want 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [3];
    logic [4:0] held;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom);
      write_word(w[i]);
    end
    wait_nonempty(6);
    tick();
    held = rptr;
    checks += 2;
    if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid: got %0b want 1", dout_valid); end
    if (held !== gray(1))    begin errors++; $display("[TB] FAIL bp_first_rptr: got %0h want %0h", held, gray(1)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 3;
      if (dout !== w[0])       begin errors++; $display("[TB] FAIL bp_stall_dout[%0d]: got %0h want %0h", i, dout, w[0]); end
      if (rptr !== gray(1))    begin errors++; $display("[TB] FAIL bp_stall_rptr[%0d]: got %0h want %0h", i, rptr, gray(1)); end
      if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall_valid[%0d]: got %0b want 1", i, dout_valid); end
    end
    dout_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks += 2;
      if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_valid[%0d]: got %0b want 1", k, dout_valid); end
      if (dout !== w[k])       begin errors++; $display("[TB] FAIL bp_resume_dout[%0d]: got %0h want %0h", k, dout, w[k]); end
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained_valid: got %0b want 0", dout_valid); end
  endtask

  task automatic test_wrap_stream();
    int pops;
    int cyc;
    logic [4:0] prev;
    logic [7:0] exp;
    do_reset();
    prev = rptr;
    cyc  = 0;
    while (consumed < 40 && cyc < 3000) begin
      pops = consumed + (dout_valid ? 1 : 0);
      checks += 5;
      if (rptr !== gray(pops)) begin errors++; $display("[TB] FAIL wrap_rptr: got %0h want %0h", rptr, gray(pops)); end
      if (int'(raddr) != pops % 16) begin errors++; $display("[TB] FAIL wrap_raddr: got %0d want %0d", raddr, pops % 16); end
      if (int'(rptr[4]) != (pops / 16) % 2) begin errors++; $display("[TB] FAIL wrap_msb: got %0b want %0d at pop %0d", rptr[4], (pops / 16) % 2, pops); end
      if ($countones(rptr ^ prev) > 1) begin errors++; $display("[TB] FAIL wrap_onebit: got %0h after %0h", rptr, prev); end
      if (int'(rcount) > wcnt - pops) begin errors++; $display("[TB] FAIL wrap_rcount: got %0d want <= %0d", rcount, wcnt - pops); end
      if (!rempty) begin
        checks++;
        if (wcnt <= pops) begin errors++; $display("[TB] FAIL wrap_false_nonempty: rempty=0 with written %0d loaded %0d", wcnt, pops); end
      end
      prev = rptr;
      if (wcnt < 40 && (wcnt - consumed) < 16 && $urandom_range(0, 1) == 1) write_word(8'($urandom));
      dout_ready = ($urandom_range(0, 3) != 0);
      if (dout_valid && dout_ready) begin
        exp = (q.size() > 0) ? q.pop_front() : 8'h00;
        checks++;
        if (dout !== exp) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %0h want %0h", consumed, dout, exp); end
        consumed++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (consumed != 40) begin errors++; $display("[TB] FAIL wrap_timeout: consumed %0d want 40", consumed); end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks += 4;
    if (rempty !== 1'b1)     begin errors++; $display("[TB] FAIL wrap_end_rempty: got %0b want 1", rempty); end
    if (rcount !== 5'd0)     begin errors++; $display("[TB] FAIL wrap_end_rcount: got %0d want 0", rcount); end
    if (raempty !== 1'b1)    begin errors++; $display("[TB] FAIL wrap_end_raempty: got %0b want 1", raempty); end
    if (rptr !== gray(40))   begin errors++; $display("[TB] FAIL wrap_end_rptr: got %0h want %0h", rptr, gray(40)); end
  endtask

  task automatic test_reset_midtransfer();
    do_reset();
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    wait_nonempty(6);
    tick();
    checks += 2;
    if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid: got %0b want 1", dout_valid); end
    if (rcount !== 5'd3)     begin errors++; $display("[TB] FAIL midrst_pre_rcount: got %0d want 3", rcount); end
    #2;
    rrst_n = 1'b0;
    wptr   = '0;
    #1;
    checks += 5;
    if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %0b want 0", dout_valid); end
    if (rempty !== 1'b1)     begin errors++; $display("[TB] FAIL midrst_rempty: got %0b want 1", rempty); end
    if (rcount !== 5'd0)     begin errors++; $display("[TB] FAIL midrst_rcount: got %0d want 0", rcount); end
    if (raempty !== 1'b1)    begin errors++; $display("[TB] FAIL midrst_raempty: got %0b want 1", raempty); end
    if (rptr !== 5'd0)       begin errors++; $display("[TB] FAIL midrst_rptr: got %0h want 0", rptr); end
    tick();
    tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after_valid[%0d]: got %0b want 0", i, dout_valid); end
      if (rempty !== 1'b1)     begin errors++; $display("[TB] FAIL midrst_after_rempty[%0d]: got %0b want 1", i, rempty); end
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rrst_n     = 1'b0;
    wptr       = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    $display("[TB] starting rptr_empty bench");
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_wrap_stream();
    test_reset_midtransfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 Parameter WORDSIZE, default 8: data word width in bits.
REQ-002 Parameter ADDRSIZE, default 8: memory address width; FIFO depth is 2^ADDRSIZE words.
REQ-003 Parameter AEMPTY_THRESH, default 4: raempty asserts when occupancy is at or below this value.
REQ-004 rclk  input  1  read-domain clock; the block's only clock; all state on rising edge.
REQ-005 rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wptr  input  ADDRSIZE+1  Gray-coded write pointer from the write domain (asynchronous to rclk).
REQ-007 rdata  input  WORDSIZE  memory read data, combinational from raddr.
REQ-008 dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 raddr  output  ADDRSIZE  memory read address (binary, low ADDRSIZE bits of read pointer).
REQ-010 rptr  output  ADDRSIZE+1  registered Gray-coded read pointer to the write domain.
REQ-011 rempty  output  1  registered: no unread word in memory per synchronized wptr.
REQ-012 raempty  output  1  registered: occupancy <= AEMPTY_THRESH.
REQ-013 rcount  output  ADDRSIZE+1  registered occupancy estimate (synchronized write pointer minus read pointer).
REQ-014 dout  output  WORDSIZE  registered output word.
REQ-015 dout_valid  output  1  dout holds a valid, not-yet-accepted word.

Function
REQ-016 wptr shall pass through a 2-flop synchronizer (rq1_wptr, rq2_wptr) clocked by rclk; no other logic shall sample wptr.
REQ-017 Read pointer shall be held as a binary rbin and Gray rgray (ADDRSIZE+1 bits each); rgray = rbin ^ (rbin >> 1); rptr = rgray.
REQ-018 Internal pop rinc = !rempty && (!dout_valid || dout_ready).
REQ-019 On rinc: dout <= rdata, dout_valid <= 1, rbin <= rbin+1 (modulo 2^(ADDRSIZE+1)), rgray updated accordingly.
REQ-020 Without rinc: if dout_ready, dout_valid <= 0 and dout holds; otherwise dout and dout_valid hold.
REQ-021 Simultaneous dout_valid && dout_ready && !rempty: current word consumed and next loaded in the same edge; zero bubble.
REQ-022 rempty <= (rgraynext == rq2_wptr), where rgraynext is the Gray pointer after this edge's increment.
REQ-023 rq2_wptr shall be converted Gray->binary; rcount <= (wbin_sync - rbinnext) modulo 2^(ADDRSIZE+1); raempty <= (that value <= AEMPTY_THRESH).
REQ-024 Pointer wrap: MSB of rbin toggles every 2^ADDRSIZE reads; rempty/rcount shall remain correct across wrap.
REQ-025 Latency: a wptr change first sampled at rclk edge 1 shall give rempty=0 after edge 3 and dout_valid=1 after edge 4, given dout_valid was 0.
REQ-026 rempty shall never deassert when no word is present; it may stay asserted up to 3 edges after a write (conservative).
REQ-027 rptr shall change by exactly one bit per increment.

Reset
REQ-028 rrst_n low shall asynchronously clear rbin, rgray, rq1_wptr, rq2_wptr, rcount, dout, dout_valid to 0 and set rempty=1, raempty=1.
REQ-029 Reset mid-transfer shall discard dout immediately; after release no pop shall occur until a new wptr value synchronizes.
REQ-030 Reset release is synchronous to rclk in the surrounding system; the block requires no extra deassertion synchronizer.

Verification (ADDRSIZE=4, WORDSIZE=8, AEMPTY_THRESH=4)
REQ-031 Reset, wptr=0 for 10 cycles -> rempty=1, raempty=1, dout_valid=0, rptr=0, raddr=0.
REQ-032 wptr 0->1 (Gray) with mem[0]=8'hA5, dout_ready=0 -> rempty=0 after edge 3, dout_valid=1 and dout=8'hA5 after edge 4, raddr=1, rempty=1 thereafter.
REQ-033 wptr set to Gray(6), dout_ready=1 continuously -> 6 consecutive dout_valid cycles carrying mem[0..5]; raempty=0 while rcount>4; rempty=1 after the 6th pop.
REQ-034 Backpressure: 3 words available, dout_ready=0 for 5 cycles then 1 -> dout stays at word 0 while stalled, no rptr change after the first pop, then words 1,2 on following cycles.
REQ-035 Wrap: 40 writes/reads streamed -> rptr sequence Gray-correct (one bit change per step), MSB toggles after reads 16 and 32, data order preserved.
REQ-036 rrst_n pulsed low while dout_valid=1 and rcount=3 -> dout_valid=0, rempty=1, rcount=0 immediately, before the next rclk edge.
